// File: rtl/vga_timing_checker.sv
// Sync-pair receiver: recovers raster position from hsync/vsync, measures line and
// frame periods, and declares lock after a run of good frames.
module vga_timing_checker #(
  parameter int unsigned H_TOTAL         = 800,
  parameter int unsigned V_TOTAL         = 525,
  parameter int unsigned H_SYNC          = 96,
  parameter bit          SYNC_ACTIVE_LOW = 1'b1,
  parameter int unsigned LOCK_FRAMES     = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        hsync,
  input  logic        vsync,
  output logic [10:0] pos_x,
  output logic [9:0]  pos_y,
  output logic        line_start,
  output logic        frame_start,
  output logic [10:0] h_period,
  output logic [9:0]  v_period,
  output logic        locked,
  output logic        timing_err
);

  localparam int unsigned HW = 11;
  localparam int unsigned VW = 10;
  localparam int unsigned GW = 4;
  localparam logic [HW-1:0] H_MAX = {HW{1'b1}};
  localparam logic [VW-1:0] V_MAX = {VW{1'b1}};

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic          hact_q, hact_d;
  logic          vact_q, vact_d;
  logic [HW-1:0] hcount_q, hcount_d;
  logic [HW-1:0] hwidth_q, hwidth_d;
  logic [VW-1:0] vcount_q, vcount_d;
  logic [HW-1:0] h_period_q, h_period_d;
  logic [VW-1:0] v_period_q, v_period_d;
  logic          line_bad_q, line_bad_d;
  logic [GW-1:0] good_cnt_q, good_cnt_d;
  logic          locked_q, locked_d;
  logic          timing_err_q, timing_err_d;
  logic          line_start_q, line_start_d;
  logic          frame_start_q, frame_start_d;

  logic          h_lead, h_trail, v_lead;
  logic          line_fault, frame_good;

  // Edge detection, counters, per-line checks and the lock FSM next-state.
  always_comb begin
    hact_d        = SYNC_ACTIVE_LOW ? ~hsync : hsync;
    vact_d        = SYNC_ACTIVE_LOW ? ~vsync : vsync;
    h_lead        = hact_d & ~hact_q;
    h_trail       = ~hact_d & hact_q;
    v_lead        = vact_d & ~vact_q;

    state_d       = state_q;
    hcount_d      = hcount_q;
    hwidth_d      = hwidth_q;
    vcount_d      = vcount_q;
    h_period_d    = h_period_q;
    v_period_d    = v_period_q;
    good_cnt_d    = good_cnt_q;
    locked_d      = locked_q;
    timing_err_d  = 1'b0;
    line_start_d  = h_lead;
    frame_start_d = v_lead;
    line_fault    = 1'b0;

    // Line period; reaching saturation means hsync has gone missing.
    if (h_lead) begin
      hcount_d   = '0;
      h_period_d = (hcount_q == H_MAX) ? H_MAX : hcount_q + HW'(1);
      if (h_period_d != HW'(H_TOTAL)) line_fault = 1'b1;
    end else if (hcount_q != H_MAX) begin
      hcount_d = hcount_q + HW'(1);
      if (hcount_d == H_MAX) line_fault = 1'b1;
    end

    if (hact_d) begin
      if (!hact_q)              hwidth_d = HW'(1);
      else if (hwidth_q != H_MAX) hwidth_d = hwidth_q + HW'(1);
    end else begin
      hwidth_d = '0;
      if (h_trail && (hwidth_q != HW'(H_SYNC))) line_fault = 1'b1;
    end

    // A coincident hsync edge starts the first line of the new frame.
    if (v_lead) begin
      v_period_d = vcount_q;
      vcount_d   = h_lead ? VW'(1) : '0;
    end else if (h_lead && (vcount_q != V_MAX)) begin
      vcount_d = vcount_q + VW'(1);
    end

    line_bad_d = line_bad_q | line_fault;
    frame_good = (vcount_q == VW'(V_TOTAL)) && !line_bad_d;

    case (state_q)
      SEARCH: begin
        if (v_lead) begin
          state_d    = MEASURE;
          good_cnt_d = '0;
        end
      end
      MEASURE: begin
        if (v_lead) begin
          if (frame_good) begin
            good_cnt_d = good_cnt_q + GW'(1);
            if (good_cnt_d == GW'(LOCK_FRAMES)) begin
              state_d  = LOCKED;
              locked_d = 1'b1;
            end
          end else begin
            good_cnt_d   = '0;
            timing_err_d = 1'b1;
          end
        end
      end
      LOCKED: begin
        if (line_fault || (v_lead && !frame_good)) begin
          state_d      = MEASURE;
          good_cnt_d   = '0;
          locked_d     = 1'b0;
          timing_err_d = 1'b1;
        end
      end
      default: begin
        state_d    = SEARCH;
        good_cnt_d = '0;
        locked_d   = 1'b0;
      end
    endcase

    if (v_lead) line_bad_d = 1'b0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= SEARCH;
      hact_q        <= 1'b0;
      vact_q        <= 1'b0;
      hcount_q      <= '0;
      hwidth_q      <= '0;
      vcount_q      <= '0;
      h_period_q    <= '0;
      v_period_q    <= '0;
      line_bad_q    <= 1'b0;
      good_cnt_q    <= '0;
      locked_q      <= 1'b0;
      timing_err_q  <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      hact_q        <= hact_d;
      vact_q        <= vact_d;
      hcount_q      <= hcount_d;
      hwidth_q      <= hwidth_d;
      vcount_q      <= vcount_d;
      h_period_q    <= h_period_d;
      v_period_q    <= v_period_d;
      line_bad_q    <= line_bad_d;
      good_cnt_q    <= good_cnt_d;
      locked_q      <= locked_d;
      timing_err_q  <= timing_err_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign pos_x       = hcount_q;
  assign pos_y       = vcount_q;
  assign h_period    = h_period_q;
  assign v_period    = v_period_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign locked      = locked_q;
  assign timing_err  = timing_err_q;

endmodule

// File: tb/tb_vga_timing_checker.sv
// Bench for vga_timing_checker: a small sync generator with injected faults, checked
// every cycle against a timestamp-based reference model plus directed scenarios.
module tb_vga_timing_checker;

  localparam int HT = 40;
  localparam int VT = 12;
  localparam int HS = 6;
  localparam int VS = 2;
  localparam int LF = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        hsync = 1'b1;
  logic        vsync = 1'b1;
  logic [10:0] pos_x;
  logic [9:0]  pos_y;
  logic        line_start;
  logic        frame_start;
  logic [10:0] h_period;
  logic [9:0]  v_period;
  logic        locked;
  logic        timing_err;

  vga_timing_checker #(
    .H_TOTAL(HT), .V_TOTAL(VT), .H_SYNC(HS), .SYNC_ACTIVE_LOW(1'b1), .LOCK_FRAMES(LF)
  ) dut (
    .clock(clock), .reset(reset), .hsync(hsync), .vsync(vsync),
    .pos_x(pos_x), .pos_y(pos_y), .line_start(line_start), .frame_start(frame_start),
    .h_period(h_period), .v_period(v_period), .locked(locked), .timing_err(timing_err)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;
  int err_seen = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: timestamps of sync edges since reset release.
  int m_n, m_last_he, m_lead, m_edges, m_edges_at_ve, m_run;
  bit m_ha_prev, m_va_prev, m_bad, m_armed, m_locked;
  int e_px, e_py, e_hp, e_vp;
  bit e_ls, e_fs, e_lk, e_err;

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic model_reset();
    m_n = 0; m_last_he = 0; m_lead = 0; m_edges = 0; m_edges_at_ve = 0; m_run = 0;
    m_ha_prev = 0; m_va_prev = 0; m_bad = 0; m_armed = 0; m_locked = 0;
    e_px = 0; e_py = 0; e_hp = 0; e_vp = 0; e_ls = 0; e_fs = 0; e_lk = 0; e_err = 0;
  endtask

  task automatic model_step();
    bit ha, va, he, ht, ve, fault, good;
    int frame_lines;
    m_n++;
    ha = !hsync;
    va = !vsync;
    he = ha && !m_ha_prev;
    ht = !ha && m_ha_prev;
    ve = va && !m_va_prev;
    fault = 0;
    good = 0;
    e_err = 0;
    e_ls = he;
    e_fs = ve;
    if (he) begin
      e_hp = imin(m_n - m_last_he, 2047);
      if (e_hp != HT) fault = 1;
      m_last_he = m_n;
      m_lead = m_n;
    end else if (m_n - m_last_he == 2047) begin
      fault = 1;
    end
    if (ht && (imin(m_n - m_lead, 2047) != HS)) fault = 1;
    e_px = imin(m_n - m_last_he, 2047);
    frame_lines = imin(m_edges - m_edges_at_ve, 1023);
    if (ve) begin
      e_vp = frame_lines;
      m_edges_at_ve = m_edges;
    end
    if (he) m_edges++;
    e_py = imin(m_edges - m_edges_at_ve, 1023);
    m_bad = m_bad | fault;
    if (ve) good = (frame_lines == VT) && !m_bad;
    if (!m_armed) begin
      if (ve) begin m_armed = 1; m_run = 0; end
    end else if (m_locked) begin
      if (fault || (ve && !good)) begin e_err = 1; m_locked = 0; m_run = 0; end
    end else if (ve) begin
      if (good) begin
        m_run++;
        if (m_run == LF) m_locked = 1;
      end else begin
        m_run = 0;
        e_err = 1;
      end
    end
    if (ve) m_bad = 0;
    e_lk = m_locked;
    m_ha_prev = ha;
    m_va_prev = va;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    model_step();
    check_eq("pos_x", 32'(pos_x), 32'(e_px));
    check_eq("pos_y", 32'(pos_y), 32'(e_py));
    check_eq("h_period", 32'(h_period), 32'(e_hp));
    check_eq("v_period", 32'(v_period), 32'(e_vp));
    check_eq("line_start", 32'(line_start), 32'(e_ls));
    check_eq("frame_start", 32'(frame_start), 32'(e_fs));
    check_eq("locked", 32'(locked), 32'(e_lk));
    check_eq("timing_err", 32'(timing_err), 32'(e_err));
    if (timing_err === 1'b1) err_seen++;
  endtask

  task automatic run_line(input int len, input int hw, input bit vact, input int x0);
    for (int x = x0; x < len; x++) begin
      hsync = (x < hw) ? 1'b0 : 1'b1;
      vsync = vact ? 1'b0 : 1'b1;
      tick();
    end
  endtask

  task automatic run_frame(input int nlines, input int bad_line, input int bad_len,
                           input int bad_hw, input int y0);
    for (int y = y0; y < nlines; y++) begin
      if (y == bad_line) run_line(bad_len, bad_hw, (y < VS), 0);
      else               run_line(HT, HS, (y < VS), 0);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_pos_x"}, 32'(pos_x), 0);
    check_eq({tag, "_pos_y"}, 32'(pos_y), 0);
    check_eq({tag, "_h_period"}, 32'(h_period), 0);
    check_eq({tag, "_v_period"}, 32'(v_period), 0);
    check_eq({tag, "_line_start"}, 32'(line_start), 0);
    check_eq({tag, "_frame_start"}, 32'(frame_start), 0);
    check_eq({tag, "_locked"}, 32'(locked), 0);
    check_eq({tag, "_timing_err"}, 32'(timing_err), 0);
  endtask

  initial begin
    int r, d, bl;
    model_reset();
    #23;
    check_all_zero("rst");
    @(negedge clock);
    reset = 1'b1;
    model_reset();

    // Start mid-frame, then lock on clean timing at the third vsync edge.
    for (int y = 8; y < VT; y++) run_line(HT, HS, 0, 0);
    run_frame(VT, -1, HT, HS, 0);
    run_frame(VT, -1, HT, HS, 0);
    check_eq("pre_lock", 32'(locked), 0);
    check_eq("no_err_acq", 32'(err_seen), 0);
    hsync = 1'b0; vsync = 1'b0;
    tick();
    check_eq("lock_3rd_ve", 32'(locked), 1);
    check_eq("lock_h_period", 32'(h_period), HT);
    check_eq("lock_v_period", 32'(v_period), VT);
    check_eq("coinc_pos_y", 32'(pos_y), 1);
    check_eq("coinc_line_start", 32'(line_start), 1);
    check_eq("coinc_frame_start", 32'(frame_start), 1);
    run_line(HT, HS, 1, 1);
    run_frame(VT, -1, HT, HS, 1);

    // Stretched line while locked.
    err_seen = 0;
    run_frame(VT, 5, HT + 1, HS, 0);
    check_eq("stretch_err", 32'(err_seen), 1);
    check_eq("stretch_unlock", 32'(locked), 0);
    run_frame(VT, -1, HT, HS, 0);
    run_frame(VT, -1, HT, HS, 0);
    run_frame(VT, -1, HT, HS, 0);
    check_eq("relock", 32'(locked), 1);

    // Narrow hsync while locked.
    err_seen = 0;
    run_frame(VT, 3, HT, HS - 1, 0);
    check_eq("narrow_err", 32'(err_seen), 1);
    check_eq("narrow_unlock", 32'(locked), 0);

    // Short frame while measuring, then recovery.
    err_seen = 0;
    run_frame(VT, -1, HT, HS, 0);
    run_frame(VT - 1, -1, HT, HS, 0);
    run_frame(VT, -1, HT, HS, 0);
    check_eq("short_err", 32'(err_seen), 2);
    check_eq("short_no_lock", 32'(locked), 0);
    run_frame(VT, -1, HT, HS, 0);
    check_eq("short_no_lock2", 32'(locked), 0);
    run_frame(VT, -1, HT, HS, 0);
    check_eq("short_relock", 32'(locked), 1);
    check_eq("short_err_total", 32'(err_seen), 2);

    // Randomized faults, model-checked every cycle.
    for (int f = 0; f < 20; f++) begin
      r = int'($urandom_range(0, 4));
      d = int'($urandom_range(1, 3));
      if ($urandom_range(0, 1) == 1) d = -d;
      bl = int'($urandom_range(0, VT - 1));
      case (r)
        0:       run_frame(VT + ((d > 0) ? 1 : -1), -1, HT, HS, 0);
        1:       run_frame(VT, bl, HT + d, HS, 0);
        2:       run_frame(VT, bl, HT, HS + ((d > 0) ? 1 : -1), 0);
        default: run_frame(VT, -1, HT, HS, 0);
      endcase
    end

    // Mid-frame asynchronous reset, then a missing hsync.
    for (int f = 0; f < 3; f++) run_frame(VT, -1, HT, HS, 0);
    check_eq("pre_rst_lock", 32'(locked), 1);
    run_line(HT, HS, 1, 0);
    run_line(HT, HS, 1, 0);
    run_line(17, HS, 0, 0);
    #2;
    reset = 1'b0;
    #1;
    check_all_zero("midrst");
    hsync = 1'b1; vsync = 1'b1;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    model_reset();
    repeat (2100) tick();
    check_eq("sat_pos_x", 32'(pos_x), 2047);
    check_eq("sat_no_lock", 32'(locked), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
